// File: rtl/sprite_rom_arbiter.sv
// Round-robin arbiter sharing one sprite ROM among NREQ requesters, with a
// tagged return pipeline and a per-frame conflict counter.
module sprite_rom_arbiter #(
  parameter int              NREQ    = 8,
  parameter int              AW      = 12,
  parameter int              DW      = 8,
  parameter int              ROM_LAT = 1,
  parameter logic [DW-1:0]   TRANSP  = 8'hE3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enb,
  input  logic                     frame_start,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*AW-1:0]       addr_in,
  output logic [AW-1:0]            rom_addr,
  output logic                     rom_rden,
  input  logic [DW-1:0]            rom_q,
  output logic [NREQ-1:0]          gnt,
  output logic                     rd_valid,
  output logic [$clog2(NREQ)-1:0]  rd_tag,
  output logic [DW-1:0]            rd_data,
  output logic                     rd_opaque,
  output logic [15:0]              conflict_cnt
);

  localparam int TW = $clog2(NREQ);

  logic [TW-1:0]   ptr;
  logic [TW-1:0]   scan;
  logic [TW-1:0]   win_idx;
  logic [TW-1:0]   ptr_next;
  logic            win_found;
  logic            grant;
  logic [NREQ-1:0] win_onehot;
  logic            multi_req;

  logic            pipe_vld [0:ROM_LAT];
  logic [TW-1:0]   pipe_tag [0:ROM_LAT];

  // Scan from ptr upward, wrapping, and take the first requester found.
  always_comb begin
    win_found  = 1'b0;
    win_idx    = '0;
    scan       = '0;
    win_onehot = '0;
    for (int i = 0; i < NREQ; i++) begin
      scan = TW'((int'(ptr) + i) % NREQ);
      if (!win_found && req[scan]) begin
        win_found = 1'b1;
        win_idx   = scan;
      end
    end
    win_onehot[win_idx] = win_found;
    ptr_next = TW'((int'(win_idx) + 1) % NREQ);
  end

  assign grant     = enb && win_found;
  assign multi_req = |(req & (req - NREQ'(1)));
  assign rd_opaque = rd_valid && (rd_data != TRANSP);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt      <= '0;
      rom_rden <= 1'b0;
      rom_addr <= '0;
      ptr      <= '0;
    end else begin
      if (grant) begin
        gnt      <= win_onehot;
        rom_rden <= 1'b1;
        rom_addr <= addr_in[win_idx*AW +: AW];
        ptr      <= ptr_next;
      end else begin
        gnt      <= '0;
        rom_rden <= 1'b0;
      end
      // Frame start re-centres priority on requester 0 after this cycle's arbitration.
      if (frame_start) begin
        ptr <= '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i <= ROM_LAT; i++) begin
        pipe_vld[i] <= 1'b0;
        pipe_tag[i] <= '0;
      end
      rd_valid <= 1'b0;
      rd_tag   <= '0;
      rd_data  <= '0;
    end else begin
      pipe_vld[0] <= grant;
      pipe_tag[0] <= win_idx;
      for (int i = 1; i <= ROM_LAT; i++) begin
        pipe_vld[i] <= pipe_vld[i-1];
        pipe_tag[i] <= pipe_tag[i-1];
      end
      // The last stage lines up with the cycle the ROM presents that read's data.
      rd_valid <= pipe_vld[ROM_LAT];
      if (pipe_vld[ROM_LAT]) begin
        rd_tag  <= pipe_tag[ROM_LAT];
        rd_data <= rom_q;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      conflict_cnt <= '0;
    end else if (frame_start) begin
      conflict_cnt <= multi_req ? 16'd1 : 16'd0;
    end else if (multi_req && (conflict_cnt != 16'hFFFF)) begin
      conflict_cnt <= conflict_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Directed bench for sprite_rom_arbiter: a round-robin reference model pushes
// expected returns onto a scoreboard that is drained as rd_valid is due.
module tb_sprite_rom_arbiter;

  localparam int NREQ = 8;
  localparam int AW   = 12;
  localparam int DW   = 8;
  localparam int LAT  = 3;

  logic              clk;
  logic              rst;
  logic              enb;
  logic              frame_start;
  logic [NREQ-1:0]   req;
  logic [NREQ*AW-1:0] addr_in;
  logic [AW-1:0]     rom_addr;
  logic              rom_rden;
  logic [DW-1:0]     rom_q;
  logic [NREQ-1:0]   gnt;
  logic              rd_valid;
  logic [2:0]        rd_tag;
  logic [DW-1:0]     rd_data;
  logic              rd_opaque;
  logic [15:0]       conflict_cnt;

  logic [AW-1:0]     addr_tab [NREQ];

  typedef struct {
    int         due;
    logic [2:0] tag;
    logic [7:0] data;
  } ret_t;

  ret_t        sb [$];
  int          cyc;
  int          checks;
  int          passes;
  int          m_ptr;
  logic [7:0]  exp_gnt;
  logic        exp_rden;
  logic [11:0] exp_addr;
  logic [15:0] exp_cnt;

  sprite_rom_arbiter dut (
    .clk          (clk),
    .rst          (rst),
    .enb          (enb),
    .frame_start  (frame_start),
    .req          (req),
    .addr_in      (addr_in),
    .rom_addr     (rom_addr),
    .rom_rden     (rom_rden),
    .rom_q        (rom_q),
    .gnt          (gnt),
    .rd_valid     (rd_valid),
    .rd_tag       (rd_tag),
    .rd_data      (rd_data),
    .rd_opaque    (rd_opaque),
    .conflict_cnt (conflict_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < NREQ; g++) begin : g_pack
    assign addr_in[g*AW +: AW] = addr_tab[g];
  end

  function automatic logic [7:0] rom_fn(input logic [11:0] a);
    return a[7:0] ^ 8'h5A;
  endfunction

  // One-cycle-latency synchronous ROM.
  always @(posedge clk) rom_q <= rom_fn(rom_addr);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("[TB] FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
  endtask

  task automatic checkOutput();
    chk("gnt", 32'(gnt), 32'(exp_gnt));
    chk("rom_rden", 32'(rom_rden), 32'(exp_rden));
    chk("rom_addr", 32'(rom_addr), 32'(exp_addr));
    chk("conflict_cnt", 32'(conflict_cnt), 32'(exp_cnt));
    if (sb.size() > 0 && sb[0].due == cyc) begin
      chk("rd_valid", 32'(rd_valid), 32'd1);
      chk("rd_tag", 32'(rd_tag), 32'(sb[0].tag));
      chk("rd_data", 32'(rd_data), 32'(sb[0].data));
      chk("rd_opaque", 32'(rd_opaque), (sb[0].data != 8'hE3) ? 32'd1 : 32'd0);
      void'(sb.pop_front());
    end else begin
      chk("rd_valid_idle", 32'(rd_valid), 32'd0);
      chk("rd_opaque_idle", 32'(rd_opaque), 32'd0);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] r, input logic e, input logic fs);
    int   w;
    logic found;
    ret_t ent;
    req = r;
    enb = e;
    frame_start = fs;
    found = 1'b0;
    w = 0;
    for (int i = 0; i < NREQ; i++) begin
      if (!found && r[(m_ptr + i) % NREQ]) begin
        found = 1'b1;
        w = (m_ptr + i) % NREQ;
      end
    end
    if (e && found) begin
      exp_gnt  = 8'd1 << w;
      exp_rden = 1'b1;
      exp_addr = addr_tab[w];
      m_ptr    = (w + 1) % NREQ;
      ent.due  = cyc + LAT;
      ent.tag  = 3'(w);
      ent.data = rom_fn(addr_tab[w]);
      sb.push_back(ent);
    end else begin
      exp_gnt  = 8'd0;
      exp_rden = 1'b0;
    end
    if (fs) m_ptr = 0;
    if (fs) exp_cnt = ($countones(r) >= 2) ? 16'd1 : 16'd0;
    else if ($countones(r) >= 2 && exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
    @(posedge clk);
    cyc++;
    #1;
    checkOutput();
  endtask

  task automatic doReset();
    rst = 1'b1;
    #2;
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_rom_rden", 32'(rom_rden), 32'd0);
    chk("rst_rom_addr", 32'(rom_addr), 32'd0);
    chk("rst_rd_valid", 32'(rd_valid), 32'd0);
    chk("rst_rd_tag", 32'(rd_tag), 32'd0);
    chk("rst_rd_data", 32'(rd_data), 32'd0);
    chk("rst_conflict_cnt", 32'(conflict_cnt), 32'd0);
    @(posedge clk);
    cyc++;
    #1;
    rst = 1'b0;
    m_ptr = 0;
    exp_gnt = '0;
    exp_rden = 1'b0;
    exp_addr = '0;
    exp_cnt = '0;
    sb.delete();
  endtask

  initial begin
    rst = 1'b0;
    enb = 1'b0;
    frame_start = 1'b0;
    req = '0;
    cyc = 0;
    checks = 0;
    passes = 0;
    for (int i = 0; i < NREQ; i++) addr_tab[i] = 12'h0A3 + 12'(i);
    #1;
    doReset();

    // Single requester, address 0x0A5 on slice 2.
    for (int i = 0; i < 5; i++) applyStimulus(8'b0000_0100, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(8'h00, 1'b1, 1'b0);

    // Re-centre on 0, then all requesters for 16 cycles.
    applyStimulus(8'h00, 1'b1, 1'b1);
    for (int i = 0; i < 16; i++) applyStimulus(8'hFF, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(8'h00, 1'b1, 1'b0);

    // Move ptr to 5, then contend between 5 and 0.
    applyStimulus(8'h10, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(8'b0010_0001, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(8'h00, 1'b1, 1'b0);

    // Transparent then opaque pixel.
    addr_tab[3] = 12'h0B9;
    addr_tab[4] = 12'h046;
    applyStimulus(8'h08, 1'b1, 1'b0);
    applyStimulus(8'h10, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(8'h00, 1'b1, 1'b0);

    // Four grants back to back, then enable dropped while reads drain.
    for (int i = 0; i < 4; i++) applyStimulus(8'h0F, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) applyStimulus(8'h0F, 1'b0, 1'b0);

    // Frame start clears the counter and favours index 0.
    applyStimulus(8'h00, 1'b1, 1'b1);
    applyStimulus(8'h81, 1'b1, 1'b0);
    applyStimulus(8'hFF, 1'b1, 1'b1);
    applyStimulus(8'hFF, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus(8'h00, 1'b1, 1'b0);

    // Two reads in flight, then a one-cycle reset.
    applyStimulus(8'h03, 1'b1, 1'b0);
    applyStimulus(8'h03, 1'b1, 1'b0);
    doReset();
    for (int i = 0; i < 5; i++) applyStimulus(8'h00, 1'b1, 1'b0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
